// File: rtl/conv2d_warb_pkg.sv
// Shared types and defaults for the conv2d write-master arbiter.
// CONV2D_WARB_PRIO_EN (see conv2d_rr_pick) selects fixed-priority picking.
package conv2d_warb_pkg;

    localparam int AW_DEF = 30;
    localparam int DW_DEF = 128;
    localparam int N_DEF  = 4;
    localparam int LW_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_GO,
        ST_BUSY,
        ST_FIN
    } warb_state_e;

    // Shift that turns a word count into a byte count.
    function automatic int byte_shift(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BYTE_SHIFT = byte_shift(DW_DEF);

endpackage

// File: rtl/conv2d_rr_pick.sv
// Request picker: round-robin from ptr_i, or lowest-index-wins when
// CONV2D_WARB_PRIO_EN is defined.
module conv2d_rr_pick
    import conv2d_warb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

`ifdef CONV2D_WARB_PRIO_EN
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        // Walk downwards so the lowest requesting index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
    end
`else
    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/conv2d_wmst_arb.sv
// Shares one Avalon write master between N conv2d output writers, one burst
// at a time. Define CONV2D_WARB_PRIO_EN for fixed priority instead of round-robin.
module conv2d_wmst_arb
    import conv2d_warb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int N  = N_DEF,
    parameter int LW = LW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*AW-1:0] req_base,
    input  logic [N*LW-1:0] req_len,
    input  logic [N-1:0]    req_wr,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    req_grant,
    output logic [N-1:0]    req_done,
    output logic            wmst_ctrl_fixed_location,
    output logic [AW-1:0]   wmst_ctrl_write_base,
    output logic [AW-1:0]   wmst_ctrl_write_length,
    output logic            wmst_ctrl_go,
    input  logic            wmst_ctrl_done,
    output logic            wmst_user_write_buffer,
    output logic [DW-1:0]   wmst_user_write_input_data,
    input  logic            wmst_user_buffer_full
);

    localparam int IW     = idx_w(N);
    localparam int BSHIFT = byte_shift(DW);

    warb_state_e   state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] base_q, base_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          seen_low_q, seen_low_d;

    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          can_take;
    logic          own_wr;
    logic [DW-1:0] own_data;

    conv2d_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign own_wr   = req_wr[owner_q];
    assign own_data = req_data[int'(owner_q)*DW +: DW];
    assign can_take = ~wmst_user_buffer_full & (cnt_q < len_q);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        grant_d    = grant_q;
        seen_low_d = seen_low_q;
        req_ready  = '0;
        req_done   = '0;
        wmst_ctrl_go               = 1'b0;
        wmst_user_write_buffer     = 1'b0;
        wmst_user_write_input_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d    = pick_idx;
                    base_d     = req_base[int'(pick_idx)*AW +: AW];
                    len_d      = req_len[int'(pick_idx)*LW +: LW];
                    grant_d    = pick_gnt;
                    cnt_d      = '0;
                    seen_low_d = 1'b0;
                    // A zero-length burst completes without touching the master.
                    state_d    = (req_len[int'(pick_idx)*LW +: LW] == '0) ? ST_FIN : ST_FILL;
                end
            end
            ST_FILL: begin
                req_ready[owner_q]     = can_take;
                wmst_user_write_buffer = own_wr & can_take;
                if (own_wr && can_take) begin
                    wmst_user_write_input_data = own_data;
                    cnt_d = cnt_q + LW'(1);
                end
                if (cnt_q == len_q) begin
                    state_d = ST_GO;
                end
            end
            ST_GO: begin
                if (wmst_ctrl_done) begin
                    wmst_ctrl_go = 1'b1;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Completion is the done low-to-high transition after go.
                if (!wmst_ctrl_done) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                req_done[owner_q] = 1'b1;
                grant_d = '0;
                ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            base_q     <= '0;
            grant_q    <= '0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            base_q     <= base_d;
            grant_q    <= grant_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign req_grant                = grant_q;
    assign wmst_ctrl_fixed_location = 1'b0;
    assign wmst_ctrl_write_base     = base_q;
    assign wmst_ctrl_write_length   = {{(AW-LW){1'b0}}, len_q} << BSHIFT;

endmodule
